// File: rtl/imm_gen_pkg.sv
// Shared constants and types for the pipelined immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SH  = 3'd6,
    FMT_BAD = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder producing the sign-extended XLEN value.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  // 32-bit immediate, already sign-extended to 32 bits (SH has a zero top bit)
  logic [31:0] raw;

  always_comb begin
    raw     = '0;
    fmt     = FMT_BAD;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM: begin
        // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount instead
        if (instr[13:12] == 2'b01) begin
          fmt = FMT_SH;
          raw = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
        end else begin
          fmt = FMT_I;
          raw = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        raw = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt = FMT_S;
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        raw = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      default: begin
        fmt     = FMT_BAD;
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a valid/ready handshake with a 2-entry elastic output buffer
// and a saturating illegal-opcode counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] ill_cnt_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  logic [XLEN-1:0]  imm_q [FIFO_DEPTH];
  logic [2:0]       fmt_q [FIFO_DEPTH];
  logic             ill_q [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_q [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [CNT_W-1:0] ill_cnt;
  logic             push;
  logic             pop;

  // Ready depends only on occupancy so no combinational path from out_ready_i
  assign in_ready_o  = (count != 2'(FIFO_DEPTH));
  assign out_valid_o = (count != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= '0;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ill_cnt <= '0;
    end else begin
      if (push) begin
        imm_q[wr_ptr] <= dec_imm;
        fmt_q[wr_ptr] <= dec_fmt;
        ill_q[wr_ptr] <= dec_ill;
        tag_q[wr_ptr] <= tag_i;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && dec_ill && (ill_cnt != '1)) begin
        ill_cnt <= ill_cnt + CNT_W'(1);
      end
    end
  end

  assign imm_o     = imm_q[rd_ptr];
  assign fmt_o     = fmt_q[rd_ptr];
  assign illegal_o = ill_q[rd_ptr];
  assign tag_o     = tag_q[rd_ptr];
  assign ill_cnt_o = ill_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32/CNT_W=2 instance and an XLEN=64 instance.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal;
  logic [31:0] a_instr, a_tag, a_tag_o, a_imm;
  logic [2:0]  a_fmt;
  logic [1:0]  a_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal;
  logic [31:0] b_instr, b_tag, b_tag_o;
  logic [63:0] b_imm;
  logic [2:0]  b_fmt;
  logic [15:0] b_cnt;

  exp_t qa[$];
  exp_t qb[$];
  int n_checks = 0;
  int n_fail   = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .instr_i(a_instr), .tag_i(a_tag), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .imm_o(a_imm), .fmt_o(a_fmt), .illegal_o(a_illegal), .tag_o(a_tag_o), .ill_cnt_o(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .instr_i(b_instr), .tag_i(b_tag), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .imm_o(b_imm), .fmt_o(b_fmt), .illegal_o(b_illegal), .tag_o(b_tag_o), .ill_cnt_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input int d, input logic [31:0] ins, input logic [31:0] tg,
                      input logic [63:0] ei, input logic [2:0] ef, input logic el);
    exp_t e;
    int   budget;
    e.imm = ei; e.fmt = ef; e.ill = el; e.tag = tg;
    budget = 0;
    if (d == 0) begin a_in_valid = 1'b1; a_instr = ins; a_tag = tg; end
    else        begin b_in_valid = 1'b1; b_instr = ins; b_tag = tg; end
    forever begin
      @(negedge clk);
      if ((d == 0) ? a_in_ready : b_in_ready) begin
        if (d == 0) qa.push_back(e); else qb.push_back(e);
        break;
      end
      budget++;
      if (budget > 50) begin
        n_checks++; n_fail++;
        $display("FAIL push_timeout: in_ready stuck low, got 0 expected 1");
        break;
      end
    end
    @(posedge clk); #1;
    if (d == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
  endtask

  task automatic drain(input int d);
    int budget;
    budget = 0;
    while (((d == 0) ? qa.size() : qb.size()) != 0) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 100) begin
        n_checks++; n_fail++;
        $display("FAIL drain_timeout: %0d entries never emerged, expected 0",
                 (d == 0) ? qa.size() : qb.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitors: compare the head whenever a transfer will happen on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected: got output imm 0x%0h, expected none", a_imm);
        end else begin
          e = qa.pop_front();
          check("a_imm", {32'b0, a_imm}, e.imm);
          check("a_fmt", {61'b0, a_fmt}, {61'b0, e.fmt});
          check("a_illegal", {63'b0, a_illegal}, {63'b0, e.ill});
          check("a_tag", {32'b0, a_tag_o}, {32'b0, e.tag});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected: got output imm 0x%0h, expected none", b_imm);
        end else begin
          e = qb.pop_front();
          check("b_imm", b_imm, e.imm);
          check("b_fmt", {61'b0, b_fmt}, {61'b0, e.fmt});
          check("b_illegal", {63'b0, b_illegal}, {63'b0, e.ill});
          check("b_tag", {32'b0, b_tag_o}, {32'b0, e.tag});
        end
      end
    end
  end

  initial begin
    a_in_valid = 0; a_instr = 0; a_tag = 0; a_out_ready = 0;
    b_in_valid = 0; b_instr = 0; b_tag = 0; b_out_ready = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, a_in_ready}, 64'd1);
    check("rst_imm", {32'b0, a_imm}, 64'd0);
    check("rst_fmt", {61'b0, a_fmt}, 64'd0);
    check("rst_tag", {32'b0, a_tag_o}, 64'd0);
    check("rst_cnt", {62'b0, a_cnt}, 64'd0);
    check("rst_b_out_valid", {63'b0, b_out_valid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'b0, a_in_ready}, 64'd1);

    // Single ADDI -1 with one-cycle latency
    a_out_ready = 1'b1;
    push(0, 32'hFFF00093, 32'h100, 64'hFFFF_FFFF, 3'd1, 1'b0);
    check("lat_out_valid", {63'b0, a_out_valid}, 64'd1);
    check("lat_imm", {32'b0, a_imm}, 64'hFFFF_FFFF);

    // Back-to-back stream across formats
    push(0, 32'h0020A423, 32'h104, 64'h0000_0008, 3'd2, 1'b0);
    push(0, 32'hFE000EE3, 32'h108, 64'hFFFF_FFFC, 3'd3, 1'b0);
    push(0, 32'h123452B7, 32'h10C, 64'h1234_5000, 3'd4, 1'b0);
    push(0, 32'h001000EF, 32'h110, 64'h0000_0800, 3'd5, 1'b0);
    push(0, 32'hFFFFF097, 32'h114, 64'hFFFF_F000, 3'd4, 1'b0);
    push(0, 32'h03F09093, 32'h118, 64'h0000_001F, 3'd6, 1'b0);
    push(0, 32'h002081B3, 32'h11C, 64'h0000_0000, 3'd0, 1'b0);
    drain(0);

    // XLEN=64 instance
    b_out_ready = 1'b1;
    push(1, 32'h03F09093, 32'h200, 64'h0000_0000_0000_003F, 3'd6, 1'b0);
    push(1, 32'hFFF00093, 32'h204, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    push(1, 32'h4030D093, 32'h208, 64'h0000_0000_0000_0003, 3'd6, 1'b0);
    push(1, 32'h800000B7, 32'h20C, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    drain(1);

    // Backpressure: head holds, third word waits for a freed slot
    a_out_ready = 1'b0;
    push(0, 32'h00508093, 32'h300, 64'd5, 3'd1, 1'b0);
    check("bp_in_ready_1", {63'b0, a_in_ready}, 64'd1);
    push(0, 32'h00A08093, 32'h304, 64'd10, 3'd1, 1'b0);
    check("bp_in_ready_full", {63'b0, a_in_ready}, 64'd0);
    check("bp_head_imm", {32'b0, a_imm}, 64'd5);
    fork
      push(0, 32'h00F08093, 32'h308, 64'd15, 3'd1, 1'b0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("bp_hold_imm", {32'b0, a_imm}, 64'd5);
          check("bp_hold_tag", {32'b0, a_tag_o}, 64'h300);
        end
        a_out_ready = 1'b1;
      end
    join
    drain(0);

    // Illegal opcodes and counter saturation at CNT_W=2
    push(0, 32'h0000007F, 32'h400, 64'd0, 3'd7, 1'b1);
    push(0, 32'h0000007F, 32'h404, 64'd0, 3'd7, 1'b1);
    push(0, 32'h0000007F, 32'h408, 64'd0, 3'd7, 1'b1);
    check("ill_cnt_3", {62'b0, a_cnt}, 64'd3);
    push(0, 32'h0000007F, 32'h40C, 64'd0, 3'd7, 1'b1);
    check("ill_cnt_sat", {62'b0, a_cnt}, 64'd3);
    drain(0);

    // Asynchronous reset with the buffer full
    a_out_ready = 1'b0;
    push(0, 32'h00108093, 32'h500, 64'd1, 3'd1, 1'b0);
    push(0, 32'h00208093, 32'h504, 64'd2, 3'd1, 1'b0);
    check("pre_rst_full", {63'b0, a_in_ready}, 64'd0);
    #3 rst_n = 1'b0;
    qa.delete();
    #1;
    check("mid_rst_out_valid", {63'b0, a_out_valid}, 64'd0);
    check("mid_rst_cnt", {62'b0, a_cnt}, 64'd0);
    check("mid_rst_in_ready", {63'b0, a_in_ready}, 64'd1);
    check("mid_rst_imm", {32'b0, a_imm}, 64'd0);
    check("mid_rst_tag", {32'b0, a_tag_o}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    push(0, 32'h12300093, 32'h600, 64'h123, 3'd1, 1'b0);
    check("post_rst_lat_valid", {63'b0, a_out_valid}, 64'd1);
    check("post_rst_lat_imm", {32'b0, a_imm}, 64'h123);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate generator.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount) into the architectural, sign-extended XLEN value. B and J offsets keep bit 0 = 0.
- Sits between fetch/IF-ID and the ID stage behind a valid/ready handshake, with a 2-entry elastic output buffer.
- Keeps a saturating count of illegal/unsupported opcodes for debug.

Parameters:
- XLEN, 32, datapath width of imm_o; legal values 32 or 64.
- TAG_W, 32, width of sideband tag carried with each instruction (typically PC).
- CNT_W, 16, width of illegal-opcode counter.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  instr_i/tag_i valid.
- in_ready_o  output  1  buffer can accept this cycle.
- instr_i  input  32  instruction word.
- tag_i  input  TAG_W  sideband, passed through unchanged.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  consumer accepts head.
- imm_o  output  XLEN  decoded immediate.
- fmt_o  output  3  format: R=0 I=1 S=2 B=3 U=4 J=5 SH=6 BAD=7.
- illegal_o  output  1  opcode not in decode table.
- tag_o  output  TAG_W  tag of head entry.
- ill_cnt_o  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Decode is combinational on instr_i. The result is written into the buffer on accept (in_valid_i && in_ready_o).
- Opcode map:
  - 0010011 OP-IMM: I format. Exception: funct3 001/101 gives SH, with imm = zero-extended shamt (instr[24:20] if XLEN=32, instr[25:20] if XLEN=64).
  - 0000011 LOAD and 1100111 JALR: I.
  - 0100011 STORE: S = {instr[31:25], instr[11:7]}.
  - 1100011 BRANCH: B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - 0110111 LUI and 0010111 AUIPC: U = {instr[31:12], 12'b0}.
  - 1101111 JAL: J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - 0110011 OP: R, imm = 0.
  - Any other opcode: BAD, imm = 0, illegal_o = 1.
- Sign extension: I/S/B/U/J sign-extend from their top bit (instr[31]) to XLEN. SH is zero-extended.
- Buffer:
  - 2-entry FIFO with wr_ptr, rd_ptr (1 bit each) and count (0..2).
  - Outputs are driven directly from the head entry registers.
  - in_ready_o = (count != 2). It is combinational from count only, never from out_ready_i.
  - out_valid_o = (count != 0).
- Latency and throughput:
  - Accept at edge N → out_valid_o high and data visible after edge N (1 cycle).
  - Sustained 1 instruction/cycle when out_ready_i stays high.
- Boundary conditions:
  - Push and pop in the same cycle with count==1: count stays 1; the new entry becomes head on the next cycle.
  - count==2: no push is possible. A pop frees a slot, so in_ready_o rises the cycle after the pop.
  - count==0: out_ready_i is ignored.
  - While out_valid_o && !out_ready_i, all head outputs hold stable.
  - Pointers wrap modulo 2.
- ill_cnt_o increments on each accepted BAD instruction and saturates at all-ones.
- Reset (asynchronous, any time including mid-transfer):
  - Effects: count=0, pointers=0, out_valid_o=0, ill_cnt_o=0.
  - Entry data registers clear to 0, so imm_o=0, fmt_o=0, illegal_o=0, tag_o=0.
  - in_ready_o=1 while in reset and immediately after it.
  - In-flight entries are discarded.
- XLEN values other than 32/64 trigger an elaboration-time error.

Decomposition:
- Package imm_gen_pkg holds: opcode constants (OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP); fmt_e enum with 3-bit codes as above; FIFO_DEPTH=2.
- Sub-module imm_decode (combinational, parameter XLEN) takes instr and produces {imm, fmt, illegal}.
- The top level holds the FIFO, handshake and counter.

Test Plan:
- Reset then push 0xFFF00093 (ADDI -1), out_ready_i=1 → next cycle out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1, illegal_o=0.
- Back-to-back pushes of 0x0020A423 (SW 8), 0xFE000EE3 (BEQ -4), 0x123452B7 (LUI), 0x001000EF (JAL +2048) → imm_o 0x00000008, 0xFFFFFFFC, 0x12345000, 0x00000800 on consecutive cycles; fmt_o 2, 3, 4, 5; tags preserved.
- XLEN=64, push 0x03F09093 (SLLI shamt 63) → imm_o=0x000000000000003F, fmt_o=6. Push 0xFFF00093 → imm_o=0xFFFFFFFFFFFFFFFF.
- Backpressure: out_ready_i=0, push 3 valid words → first two accepted, in_ready_o=0 from the cycle after the second accept, head holds the first word. Set out_ready_i=1 → all three words emerge in order with no loss or duplication.
- Push 0x0000007F three times → illegal_o=1, fmt_o=7, imm_o=0, ill_cnt_o=3. With CNT_W=2, a 4th illegal push leaves ill_cnt_o saturated at 3.
- Assert rst_i low with count==2 mid-stream → out_valid_o=0 and ill_cnt_o=0 asynchronously, in_ready_o=1. After release, the first push emerges with 1-cycle latency.
